// File: rtl/lcd_panel_writer_pkg.sv
// lcd_pkg: shared defaults and types for the LCD panel writer slice.
// Optional feature macro: LCD_PNL_CHECKSUM_EN (adds the CSUM reader state).
package lcd_pkg;

    localparam int LCD_PIX_W     = 8;
    localparam int LCD_FRAME_PIX = 16;

    typedef logic bank_t;

`ifdef LCD_PNL_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } rd_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
    } rd_state_t;
`endif

endpackage

// File: rtl/lcd_panel_writer_if.sv
// Pixel capture and panel streaming signals of the LCD panel writer.
// Optional feature macro: LCD_PNL_CHECKSUM_EN (no effect on this interface).
interface lcd_panel_writer_if
    import lcd_pkg::*;
#(
    parameter int PIX_W = LCD_PIX_W
);

    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic [PIX_W-1:0] pnl_data;
    logic             pnl_valid;
    logic             pnl_ready;
    logic             pnl_sof;
    logic             pnl_eof;

    modport master (
        output pix_data,
        output pix_valid,
        output pnl_ready,
        input  pnl_data,
        input  pnl_valid,
        input  pnl_sof,
        input  pnl_eof
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pnl_ready,
        output pnl_data,
        output pnl_valid,
        output pnl_sof,
        output pnl_eof
    );

endinterface

// File: rtl/lcd_pingpong_buf.sv
// Two-bank ping-pong frame store with per-bank full flags.
// A bank released by the reader in the same cycle reports as free.
// Optional feature macro: LCD_PNL_CHECKSUM_EN (no effect on this module).
module lcd_pingpong_buf
    import lcd_pkg::*;
#(
    parameter int PIX_W     = LCD_PIX_W,
    parameter int FRAME_PIX = LCD_FRAME_PIX
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  bank_t                        wr_bank,
    input  logic [$clog2(FRAME_PIX)-1:0] wr_addr,
    input  logic [PIX_W-1:0]             wr_data,
    input  bank_t                        rd_bank,
    input  logic [$clog2(FRAME_PIX)-1:0] rd_addr,
    output logic [PIX_W-1:0]             rd_data,
    input  logic                         set_full,
    input  bank_t                        set_bank,
    input  logic                         release_full,
    input  bank_t                        release_bank,
    output logic [1:0]                   full,
    output logic [1:0]                   free
);

    logic [PIX_W-1:0] mem [2][FRAME_PIX];
    logic [1:0]       set_vec;
    logic [1:0]       rel_vec;

    // Decode the set/release requests into per-bank strobes
    always_comb begin
        set_vec = '0;
        rel_vec = '0;
        if (set_full) begin
            set_vec[set_bank] = 1'b1;
        end
        if (release_full) begin
            rel_vec[release_bank] = 1'b1;
        end
    end

    assign free    = ~full | rel_vec;
    assign rd_data = mem[rd_bank][rd_addr];

    // Pixel storage; contents need no reset because the full flags gate use
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Full flags: the writer sets a bank on its last pixel, the reader releases it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= '0;
        end else begin
            full <= (full & ~rel_vec) | set_vec;
        end
    end

endmodule

// File: rtl/lcd_panel_writer.sv
// LCD panel writer: captures 16-pixel bursts into a ping-pong buffer and
// replays each complete frame to the panel over valid/ready with sof/eof.
// Optional feature macro: LCD_PNL_CHECKSUM_EN (appends a modulo-sum beat).
module lcd_panel_writer
    import lcd_pkg::*;
#(
    parameter int PIX_W     = LCD_PIX_W,
    parameter int FRAME_PIX = LCD_FRAME_PIX,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    lcd_panel_writer_if.slave  bus,
    output logic               frame_err,
    output logic               ovf,
    output logic [CNT_W-1:0]   frame_cnt
);

    localparam int             AW   = $clog2(FRAME_PIX);
    localparam logic [AW-1:0]  LAST = AW'(FRAME_PIX - 1);

    logic [PIX_W-1:0] pix_data_q;
    logic             pix_valid_q;
    bank_t            wr_sel, wr_sel_n;
    bank_t            rd_sel;
    logic [AW-1:0]    wr_cnt, wr_cnt_n;
    logic [AW-1:0]    rd_cnt;
    logic             dropping, dropping_n;
    logic             ovf_n, frame_err_n;
    logic             we, set_full, release_full;
    logic [1:0]       full, free;
    logic [PIX_W-1:0] rd_data;
    logic             hs;
    rd_state_t        state, state_n;
`ifdef LCD_PNL_CHECKSUM_EN
    logic [PIX_W-1:0] sum;
`endif

    lcd_pingpong_buf #(
        .PIX_W     (PIX_W),
        .FRAME_PIX (FRAME_PIX)
    ) u_buf (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .wr_bank      (wr_sel),
        .wr_addr      (wr_cnt),
        .wr_data      (pix_data_q),
        .rd_bank      (rd_sel),
        .rd_addr      (rd_cnt),
        .rd_data      (rd_data),
        .set_full     (set_full),
        .set_bank     (wr_sel),
        .release_full (release_full),
        .release_bank (rd_sel),
        .full         (full),
        .free         (free)
    );

    // Capture stage: register the controller pixel stream before the write logic
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            pix_data_q  <= bus.pix_data;
            pix_valid_q <= bus.pix_valid;
        end
    end

    // Write control: store beats, close frames, detect overflow and truncation
    always_comb begin
        we          = 1'b0;
        set_full    = 1'b0;
        wr_cnt_n    = wr_cnt;
        wr_sel_n    = wr_sel;
        dropping_n  = dropping;
        ovf_n       = 1'b0;
        frame_err_n = 1'b0;
        if (pix_valid_q) begin
            if (!dropping) begin
                if (free[wr_sel]) begin
                    we = 1'b1;
                    if (wr_cnt == LAST) begin
                        set_full = 1'b1;
                        wr_sel_n = ~wr_sel;
                        wr_cnt_n = '0;
                    end else begin
                        wr_cnt_n = wr_cnt + 1'b1;
                    end
                end else if (wr_cnt == '0) begin
                    ovf_n      = 1'b1;
                    dropping_n = 1'b1;
                end
            end
        end else begin
            dropping_n = 1'b0;
            if (!dropping && wr_cnt != '0) begin
                frame_err_n = 1'b1;
                wr_cnt_n    = '0;
            end
        end
    end

    // Write-side state and the one-cycle drop flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt    <= '0;
            wr_sel    <= 1'b0;
            dropping  <= 1'b0;
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_cnt    <= wr_cnt_n;
            wr_sel    <= wr_sel_n;
            dropping  <= dropping_n;
            ovf       <= ovf_n;
            frame_err <= frame_err_n;
        end
    end

    assign hs = bus.pnl_ready && (state != IDLE);

    // Reader state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Reader next state: start on a full bank, leave after the final beat's handshake
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (full[rd_sel]) begin
                    state_n = SEND;
                end
            end
            SEND: begin
                if (hs && rd_cnt == LAST) begin
`ifdef LCD_PNL_CHECKSUM_EN
                    state_n = CSUM;
`else
                    state_n = IDLE;
`endif
                end
            end
`ifdef LCD_PNL_CHECKSUM_EN
            CSUM: begin
                if (hs) begin
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Reader outputs: panel beat, frame markers and the bank release strobe
    always_comb begin
        bus.pnl_valid = 1'b0;
        bus.pnl_data  = '0;
        bus.pnl_sof   = 1'b0;
        bus.pnl_eof   = 1'b0;
        release_full  = 1'b0;
        case (state)
            SEND: begin
                bus.pnl_valid = 1'b1;
                bus.pnl_data  = rd_data;
                bus.pnl_sof   = (rd_cnt == '0);
`ifndef LCD_PNL_CHECKSUM_EN
                bus.pnl_eof   = (rd_cnt == LAST);
                release_full  = hs && (rd_cnt == LAST);
`endif
            end
`ifdef LCD_PNL_CHECKSUM_EN
            CSUM: begin
                bus.pnl_valid = 1'b1;
                bus.pnl_data  = sum;
                bus.pnl_eof   = 1'b1;
                release_full  = hs;
            end
`endif
            default: begin
                bus.pnl_valid = 1'b0;
            end
        endcase
    end

    // Reader datapath: pixel index, bank select, sent-frame counter and checksum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt    <= '0;
            rd_sel    <= 1'b0;
            frame_cnt <= '0;
`ifdef LCD_PNL_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            if (state == IDLE) begin
                rd_cnt <= '0;
            end else if (state == SEND && hs) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (release_full) begin
                rd_sel    <= ~rd_sel;
                frame_cnt <= frame_cnt + 1'b1;
            end
`ifdef LCD_PNL_CHECKSUM_EN
            if (state == IDLE) begin
                sum <= '0;
            end else if (state == SEND && hs) begin
                sum <= sum + rd_data;
            end
`endif
        end
    end

endmodule
